// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - decode-stage hazard detection and forwarding select unit (optional feature macro: HAZARD_FWD_EN)
module hazard_fwd_unit #(
    parameter int AW    = 5,
    parameter int DEPTH = 2,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             flush,
    output logic [DEPTH-1:0] match1,
    output logic [DEPTH-1:0] match2,
    output logic [SW-1:0]    fwd_sel1,
    output logic [SW-1:0]    fwd_sel2,
    output logic             stall,
    output logic [15:0]      stall_cnt
);

    // Shadow of in-flight producers; index 0 is EX, higher indices are older.
    logic [DEPTH-1:0] sh_v;
    logic [DEPTH-1:0] sh_we;
    logic [DEPTH-1:0] sh_ld;
    logic [AW-1:0]    sh_rd [DEPTH];

    logic             rs1_live;
    logic             rs2_live;
    logic             insert;

    // Lowest set bit wins, so the youngest producer is forwarded.
    function automatic logic [SW-1:0] youngest_sel(input logic [DEPTH-1:0] m);
        logic [SW-1:0] sel;
        sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m[k]) begin
                sel = SW'(k + 1);
            end
        end
        return sel;
    endfunction

    // A source only takes part in hazard checks if it is read and is not x0.
    always_comb begin
        rs1_live = id_valid & id_rs1_used & (id_rs1 != '0);
        rs2_live = id_valid & id_rs2_used & (id_rs2 != '0);
    end

    // Per-stage address compare against the pre-edge shadow.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match1[k] = rs1_live & sh_v[k] & sh_we[k] & (sh_rd[k] == id_rs1);
            match2[k] = rs2_live & sh_v[k] & sh_we[k] & (sh_rd[k] == id_rs2);
        end
    end

`ifdef HAZARD_FWD_EN
    // Forwarding covers everything except a load still in EX, which costs one bubble.
    always_comb begin
        fwd_sel1 = youngest_sel(match1);
        fwd_sel2 = youngest_sel(match2);
        stall    = (match1[0] | match2[0]) & sh_ld[0];
    end
`else
    // Without forwarding, any dependence on an in-flight producer holds decode.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        stall    = (|match1) | (|match2);
    end
`endif

    // Flush wins over stall: a killed instruction never enters the shadow.
    always_comb begin
        insert = id_valid & ~stall & ~flush;
    end

    // Shadow pipeline: entry 0 takes the decode instruction or a bubble, the rest shift down.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_v  <= '0;
            sh_we <= '0;
            sh_ld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sh_rd[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sh_v[k]  <= sh_v[k-1];
                sh_we[k] <= sh_we[k-1];
                sh_ld[k] <= sh_ld[k-1];
                sh_rd[k] <= sh_rd[k-1];
            end
            sh_v[0]  <= insert;
            sh_we[0] <= insert & id_we;
            sh_ld[0] <= insert & id_is_load;
            sh_rd[0] <= id_rd;
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
